uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 868; clk cycles per serial bit, legal range 2..65535.
REQ-002 SHALL provide port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL provide port tx_start  input  1  request to send tx_data; sampled only in IDLE.
REQ-005 SHALL provide port tx_data  input  8  byte to transmit; latched in the accepting cycle.
REQ-006 SHALL provide port tx  output  1  serial line; idle-high.
REQ-007 SHALL provide port tx_busy  output  1  high while a frame is in progress.
REQ-008 SHALL provide port tx_done  output  1  one-cycle pulse on frame completion.

Function
REQ-009 SHALL implement the FSM states IDLE, START, DATA, PARITY (macro-gated), STOP.
REQ-010 SHALL accept a request when state=IDLE and tx_start=1: latch tx_data, go to START on the next edge.
REQ-011 SHALL ignore tx_start outside IDLE; the in-flight frame and its latched byte are unaffected.
REQ-012 SHALL drive tx=0 from the cycle after acceptance for exactly CLKS_PER_BIT cycles (START).
REQ-013 SHALL send DATA LSB-first, each bit held CLKS_PER_BIT cycles; a 3-bit index counts 0..7.
REQ-014 SHALL hold tx=1 for CLKS_PER_BIT cycles in STOP (one stop bit).
REQ-015 SHALL use a baud counter of width clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and clears on each state or bit change.
REQ-016 SHALL make each frame occupy 10*CLKS_PER_BIT cycles of tx (11*CLKS_PER_BIT with parity), with no gaps between bits.
REQ-017 SHALL register tx; no combinational path from any input to tx.
REQ-018 SHALL assert tx_busy in every cycle the state is not IDLE; tx_busy=0 in IDLE.
REQ-019 SHALL pulse tx_done=1 for one cycle, namely the first IDLE cycle after STOP.
REQ-020 SHALL accept a tx_start that coincides with the tx_done cycle, giving back-to-back frames with no extra idle bit.
REQ-021 SHALL keep tx=1 in IDLE regardless of tx_data.

Reset
REQ-022 SHALL, on any rising clk edge with rst=0, set state=IDLE, tx=1, tx_busy=0, tx_done=0, counters=0, data register=0.
REQ-023 SHALL abort a frame in progress when rst=0 occurs mid-frame: tx=1 on that edge, no tx_done pulse.
REQ-024 SHALL ignore tx_start in any cycle where rst=0.
REQ-025 SHALL accept a request in the first cycle after rst returns high.

Configuration
REQ-026 SHALL, with macro UART_TX_PARITY_EN defined, insert PARITY between DATA and STOP, driving the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-027 SHALL, without UART_TX_PARITY_EN, omit the PARITY state and its logic entirely, going DATA to STOP directly.

Verification (CLKS_PER_BIT=4)
REQ-028 SHALL cover reset: rst=0 for 2 cycles -> tx=1, tx_busy=0, tx_done=0.
REQ-029 SHALL cover a single byte: tx_data=8'hA5, one-cycle tx_start -> tx = 0 (4 cycles), then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 (4 cycles); tx_done pulses at cycle 41 after acceptance.
REQ-030 SHALL cover a busy-ignore: tx_start with 8'h3C at data bit 2 of an 8'h0F frame -> 8'h0F sent unaltered, no second frame.
REQ-031 SHALL cover back-to-back: 8'h55 then 8'hAA, second tx_start in the tx_done cycle -> next start bit immediately follows the stop bit; 80 contiguous frame cycles.
REQ-032 SHALL cover mid-frame reset: rst=0 during data bit 4 -> tx=1 on that edge, tx_busy=0, no tx_done, and a new frame is accepted after release.
REQ-033 SHALL cover parity with UART_TX_PARITY_EN: 8'h07 -> parity bit 1; 8'h03 -> parity bit 0; frame 44 cycles.

Source files
------------

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : 8-bit UART transmitter, LSB-first, one stop bit, registered tx.
//            Optional even parity bit enabled by macro UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int                c_CW   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0]   c_ONE  = c_CW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_CW-1:0] r_cnt,   w_cnt_nxt;
    logic [2:0]      r_idx,   w_idx_nxt;
    logic [7:0]      r_data,  w_data_nxt;
    logic            r_tx,    w_tx_nxt;
    logic            r_done,  w_done_nxt;
    logic            w_bit_end;
    logic [2:0]      w_idx_inc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign w_bit_end = (r_cnt == c_LAST);
    assign w_idx_inc = r_idx + 3'd1;

    // Next tx level is computed alongside the transition so the line is
    // registered and each bit starts on the same edge as its state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_ONE;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_tx_nxt    = r_tx;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_tx_nxt  = 1'b1;
                if (tx_start) begin
                    w_data_nxt  = tx_data;
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_data[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = ^r_data;
`else
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_idx_nxt = w_idx_inc;
                        w_tx_nxt  = r_data[w_idx_inc];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_tx_nxt    = 1'b1;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign tx      = r_tx;
    assign tx_done = r_done;
    assign tx_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire
